// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply/divide unit for the EX stage.
//
// One operation is accepted per start pulse while IDLE. The unit then performs
// one radix-2 step per cycle (shift-add multiply or restoring shift-subtract
// divide) and loads the registered result with a one-cycle done pulse.
//
// Ports:
//   CLK     in   rising-edge clock
//   RESET   in   asynchronous active-high reset
//   start   in   request strobe, sampled only in IDLE
//   op      in   funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   data1   in   rs1 operand (multiplicand / dividend)
//   data2   in   rs2 operand (multiplier / divisor)
//   flush   in   synchronous abort; wins over start and completion
//   busy    out  high in CALC and DONE
//   done    out  one-cycle pulse, result valid in that cycle
//   result  out  registered result, held until the next completion
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   When defined, divide-by-zero, signed overflow and multiply-by-zero finish
//   one edge after acceptance. Results are identical in both builds.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_data1;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg;      // product / quotient sign
    logic               r_neg_r;    // remainder sign
    logic               r_dz;
    logic               r_ovf;
    logic               r_mzero;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    // Operand sign handling at the accept edge
    logic             w_sign_a;
    logic             w_sign_b;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_dz;
    logic             w_ovf;
    logic             w_mzero;

    // MULH, MULHSU, DIV, REM treat data1 as signed; MULH, DIV, REM also data2
    assign w_sign_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign w_sign_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign w_sa     = w_sign_a & data1[WIDTH-1];
    assign w_sb     = w_sign_b & data2[WIDTH-1];
    assign w_mag_a  = w_sa ? ({WIDTH{1'b0}} - data1) : data1;
    assign w_mag_b  = w_sb ? ({WIDTH{1'b0}} - data2) : data2;
    assign w_dz     = op[2] & (data2 == {WIDTH{1'b0}});
    assign w_ovf    = op[2] & ~op[0] & (data1 == {1'b1, {(WIDTH-1){1'b0}}})
                      & (data2 == {WIDTH{1'b1}});
    assign w_mzero  = ~op[2] & ((data1 == {WIDTH{1'b0}}) | (data2 == {WIDTH{1'b0}}));

    // Restoring-division step: shift next dividend bit into the partial remainder
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;

    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_dvsr});
    // When the trial succeeds the true difference is below the divisor,
    // so the low WIDTH bits of the subtraction are exact.
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_dvsr;

    // High word of the negated product: ~hi plus carry-in from negating lo
    logic [WIDTH-1:0] w_prod_hi;
    assign w_prod_hi = r_neg ? (~r_prod[2*WIDTH-1:WIDTH]
                               + {{(WIDTH-1){1'b0}}, (r_prod[WIDTH-1:0] == {WIDTH{1'b0}})})
                             : r_prod[2*WIDTH-1:WIDTH];

    logic w_cnt_end;
    logic w_last;
    assign w_cnt_end = (r_cnt == CW'(WIDTH));
`ifdef MULDIV_EARLY_OUT_EN
    assign w_last = w_cnt_end | r_dz | r_ovf | r_mzero;
`else
    assign w_last = w_cnt_end;
`endif

    logic [WIDTH-1:0] w_norm;
    logic [WIDTH-1:0] w_result;

    // Final result selection with special-case overrides
    always_comb begin
        w_norm   = {WIDTH{1'b0}};
        w_result = {WIDTH{1'b0}};
        case (r_op)
            3'b000:                 w_norm = r_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_norm = w_prod_hi;
            3'b100, 3'b101:         w_norm = r_neg ? ({WIDTH{1'b0}} - r_quo) : r_quo;
            3'b110, 3'b111:         w_norm = r_neg_r ? ({WIDTH{1'b0}} - r_rem) : r_rem;
            default:                w_norm = {WIDTH{1'b0}};
        endcase
        if (r_mzero) begin
            w_result = {WIDTH{1'b0}};
        end else if (r_dz) begin
            w_result = r_op[1] ? r_data1 : {WIDTH{1'b1}};
        end else if (r_ovf) begin
            w_result = r_op[1] ? {WIDTH{1'b0}} : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            w_result = w_norm;
        end
    end

    // Control FSM, datapath iteration and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_cnt    <= {CW{1'b0}};
            r_op     <= 3'b000;
            r_data1  <= {WIDTH{1'b0}};
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_prod   <= {(2*WIDTH){1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= {WIDTH{1'b0}};
            r_dvsr   <= {WIDTH{1'b0}};
            r_neg    <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_mzero  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && !flush) begin
                        r_op     <= op;
                        r_data1  <= data1;
                        r_neg    <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_dz     <= w_dz;
                        r_ovf    <= w_ovf;
                        r_mzero  <= w_mzero;
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_prod   <= {(2*WIDTH){1'b0}};
                        r_rem    <= {WIDTH{1'b0}};
                        r_quo    <= w_mag_a;
                        r_dvsr   <= w_mag_b;
                        r_cnt    <= {CW{1'b0}};
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_result <= w_result;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        // Both datapaths step; only the one matching r_op is used
                        r_cnt    <= r_cnt + CW'(1);
                        r_prod   <= r_prod + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_rem    <= w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
                        r_quo    <= {r_quo[WIDTH-2:0], w_div_ge};
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_res = 32'd0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .start (start),
        .op    (op),
        .data1 (data1),
        .data2 (data2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics computed with plain 64-bit / int arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int          sa;
        int          sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f[2]) return (b == 32'd0) ||
                         (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 32'd0) || (b == 32'd0);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op, optionally poke start mid-calculation, check latency/result
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit interfere, input string tag);
        logic [31:0] exp;
        int          lat;
        int          lat_exp;
        exp     = ref_result(f, a, b);
        lat_exp = 33;
`ifdef MULDIV_EARLY_OUT_EN
        if (is_special(f, a, b)) lat_exp = 1;
`endif
        @(negedge CLK);
        start = 1'b1; op = f; data1 = a; data2 = b;
        @(posedge CLK); #1;
        start = 1'b0; op = 3'($urandom); data1 = $urandom; data2 = $urandom;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (lat < 100) begin
            @(posedge CLK); #1;
            lat++;
            if (done) break;
            if (interfere && lat == 5 && lat_exp > 8) begin
                start = 1'b1; op = 3'($urandom); data1 = $urandom; data2 = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_val({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check_val({tag, "_res"}, result, exp);
        @(posedge CLK); #1;
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_val({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check_val({tag, "_hold"}, result, exp);
        last_res = exp;
    endtask

    logic [2:0]  d_op [0:13] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                                 3'd4, 3'd6, 3'd4, 3'd6, 3'd2, 3'd0, 3'd5};
    logic [31:0] d_a  [0:13] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                                 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd5};
    logic [31:0] d_b  [0:13] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd2, 32'd12345, 32'd0};

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done;
        RESET = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; data1 = 32'd0; data2 = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_result", result, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // Directed cases from the RV32M corner list
        for (int i = 0; i < 14; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], 1'b0, $sformatf("dir%0d", i));
        end

        // start pulses during CALC must be ignored
        run_op(3'd4, 32'd1000, 32'd7, 1'b1, "intf_div");
        run_op(3'd1, 32'h1234_5678, 32'h8765_4321, 1'b1, "intf_mulh");

        // Random operations against the reference
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rf;
            logic [31:0] ra;
            logic [31:0] rb;
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op(rf, ra, rb, (i % 4) == 0, $sformatf("rnd%0d", i));
        end

        // start together with flush in IDLE is ignored
        @(negedge CLK);
        start = 1'b1; flush = 1'b1; op = 3'd0; data1 = 32'd3; data2 = 32'd4;
        @(posedge CLK); #1;
        start = 1'b0; flush = 1'b0;
        check_val("start_flush_busy", 32'(busy), 32'd0);

        // Flush around iteration 10 of MULHSU
        @(negedge CLK);
        start = 1'b1; op = 3'd2; data1 = 32'hFFFF_F000; data2 = 32'h0001_2345;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        check_val("flush_busy", 32'(busy), 32'd0);
        check_val("flush_done", 32'(done), 32'd0);
        check_val("flush_result", result, last_res);
        run_op(3'd2, 32'hFFFF_F000, 32'h0001_2345, 1'b0, "post_flush");

        // Reset in the middle of DIV 100/7
        @(negedge CLK);
        start = 1'b1; op = 3'd4; data1 = 32'd100; data2 = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_result", result, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (done) n_done++;
        end
        check_val("midrst_no_done", 32'(n_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle execution unit for the RV32M multiply/divide instructions, sitting beside the single-cycle ALU in the EX stage.
- The pipeline control acts as initiator and issues one operation with a start pulse.
- The unit is the responder: it computes over WIDTH iterations and returns a registered result with a one-cycle done pulse.
- While busy, the hazard unit stalls the pipeline.

Parameters:
- WIDTH, 32, operand/result width and iteration count; only 32 is required to be supported.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- data1  input  WIDTH  rs1 operand (multiplicand/dividend)
- data2  input  WIDTH  rs2 operand (multiplier/divisor)
- flush  input  1  synchronous abort from pipeline control
- busy  output  1  high while an operation is in progress (CALC and DONE)
- done  output  1  one-cycle pulse; result valid in that cycle
- result  output  WIDTH  registered result, held until the next accepted op completes

Behaviour:
- Reset (async, RESET=1): state=IDLE, busy=0, done=0, result=0, iteration counter=0, internal registers=0. Reset mid-operation abandons the op; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE: on an edge with start=1 and flush=0:
  - latch op, data1, data2 and operand sign flags; take magnitudes where signed (MULH: both; MULHSU: data1 only; DIV/REM: both);
  - counter=0; go to CALC; busy=1 from that edge.
  - start with flush=1 is ignored.
- CALC: one radix-2 step per cycle; counter increments; after WIDTH steps go to DONE.
- Multiply: shift-add on a 2*WIDTH product.
  - MUL returns the low word.
  - MULH/MULHSU/MULHU return the high word after sign correction (negate the 64-bit product if the sign flags differ).
- Divide: restoring shift-subtract.
  - Quotient sign = sign(data1) xor sign(data2); remainder sign = sign(data1).
- Special cases (result on the normal schedule unless the optional feature is enabled):
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> data1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- DONE: result register loaded on the CALC->DONE edge; done=1 for exactly the DONE cycle; next edge -> IDLE, busy=0.
- Latency: accept edge E0; done is high in the cycle after edge E(WIDTH+1), i.e. 33 edges for WIDTH=32. A new start is accepted earliest at the edge ending DONE+1 (back-to-back gap of one IDLE cycle).
- start while busy: ignored; no queuing.
- flush in CALC or DONE: next edge -> IDLE; busy=0, done=0; result keeps its previous value. flush has priority over start and over completion in the same cycle.
- Operand inputs are don't-care except at the accept edge.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - At the accept edge, detect divisor 0, signed overflow, or either multiply operand 0; go directly to DONE with the special result.
  - done is high in the cycle after E1 (1-edge latency).
- Undefined:
  - All ops take the full WIDTH+1 edges.
  - Special-case results are forced at the CALC->DONE edge.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset: assert RESET mid-CALC of DIV 100/7 -> immediately busy=0, done=0, result=0; no done pulse follows.
- MUL 7 * -3 (0xFFFFFFFD) -> done 33 edges after accept, result 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; overflow DIV 0x80000000/-1 -> 0x80000000, REM -> 0. Latency is 33 edges without MULDIV_EARLY_OUT_EN and 1 edge with it.
- Handshake: pulse start again during CALC with different operands -> ignored, original result returned. Exactly one done pulse; busy drops the cycle after done.
- Flush at iteration 10 of MULHSU -> IDLE next edge, no done, result unchanged; a new start the next cycle completes correctly.
